// File: rtl/vector_reduce_accum_unit_if.sv
// Vector stream, configuration bus and result stream of the vector reduce/accumulate unit.
// The master drives vectors and configuration; the slave returns results.
interface vector_reduce_accum_unit_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CW         = 2
);
  logic                         tracing;
  logic                         vec_valid;
  logic                         vec_eof;
  logic [CW-1:0]                vec_chain;
  logic [N-1:0][DATA_WIDTH-1:0] vec_data;
  logic [7:0]                   config_id;
  logic [7:0]                   config_data;
  logic                         res_valid;
  logic [N-1:0][DATA_WIDTH-1:0] res_data;

  modport master (
    output tracing, vec_valid, vec_eof, vec_chain, vec_data, config_id, config_data,
    input  res_valid, res_data
  );

  modport slave (
    input  tracing, vec_valid, vec_eof, vec_chain, vec_data, config_id, config_data,
    output res_valid, res_data
  );
endinterface

// File: rtl/vector_reduce_accum_unit.sv
// Per-chain vector reduction (pass/sum/group-sum/max) and frame accumulation in a
// two-stage pipeline; chain modes are loaded over the config bus while not tracing.
module vector_reduce_accum_unit #(
  parameter int N                  = 8,
  parameter int M                  = 4,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter logic [3*MAX_CHAINS-1:0] INITIAL_FIRMWARE = '0
) (
  input logic clk,
  input logic rst,
  vector_reduce_accum_unit_if.slave bus
);
  localparam int CW     = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int GROUPS = N / M;

  typedef enum logic [2:0] {
    MODE_PASS  = 3'd0,
    MODE_SUM   = 3'd1,
    MODE_GROUP = 3'd2,
    MODE_MAX   = 3'd3,
    MODE_ACCUM = 3'd4
  } mode_e;

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  logic [2:0]            firmware [MAX_CHAINS];
  logic [DATA_WIDTH-1:0] acc      [MAX_CHAINS];

  logic          s1_valid;
  vec_t          s1_vec;
  logic [CW-1:0] s1_chain;
  mode_e         s1_mode;
  logic          s1_eof;

  logic                  accept;
  vec_t                  next_data;
  logic                  next_valid;
  logic [DATA_WIDTH-1:0] vec_sum;
  logic [DATA_WIDTH-1:0] acc_total;
  logic [DATA_WIDTH-1:0] max_val;
  logic [DATA_WIDTH-1:0] max_idx;

  int            cfg_offset;
  logic          cfg_hit;
  logic [CW-1:0] cfg_slot;
  logic          unused_cfg_bits;

  assign accept          = bus.tracing & bus.vec_valid;
  assign cfg_offset      = int'(bus.config_id) - PERSONAL_CONFIG_ID;
  assign cfg_hit         = !bus.tracing && (cfg_offset >= 0) && (cfg_offset < MAX_CHAINS);
  assign cfg_slot        = cfg_offset[CW-1:0];
  assign unused_cfg_bits = ^bus.config_data[7:3];

  // S2 datapath: the accumulator is read here, so a result written back at the end
  // of this cycle is already visible to the vector that follows directly behind it.
  always_comb begin
    vec_sum = '0;
    for (int i = 0; i < N; i++) vec_sum = vec_sum + s1_vec[i];

    max_val = s1_vec[0];
    max_idx = '0;
    for (int i = 1; i < N; i++) begin
      if ($signed(s1_vec[i]) > $signed(max_val)) begin
        max_val = s1_vec[i];
        max_idx = DATA_WIDTH'(i);
      end
    end

    acc_total  = acc[s1_chain] + vec_sum;
    next_data  = '0;
    next_valid = s1_valid;
    case (s1_mode)
      MODE_SUM:   next_data[0] = vec_sum;
      MODE_GROUP: begin
        for (int g = 0; g < GROUPS; g++)
          for (int k = 0; k < M; k++) next_data[g] = next_data[g] + s1_vec[g*M+k];
      end
      MODE_MAX: begin
        next_data[0] = max_val;
        next_data[1] = max_idx;
      end
      MODE_ACCUM: begin
        next_data[0] = acc_total;
        next_valid   = s1_valid & s1_eof;
      end
      default:    next_data = s1_vec;
    endcase
    if (!next_valid) next_data = '0;
  end

  // Config writes come after the S2 write-back so a reconfigured chain always starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_vec        <= '0;
      s1_chain      <= '0;
      s1_mode       <= MODE_PASS;
      s1_eof        <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) begin
        firmware[c] <= INITIAL_FIRMWARE[3*c +: 3];
        acc[c]      <= '0;
      end
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_vec   <= bus.vec_data;
        s1_chain <= bus.vec_chain;
        s1_eof   <= bus.vec_eof;
        s1_mode  <= (firmware[bus.vec_chain] > 3'd4) ? MODE_PASS
                                                      : mode_e'(firmware[bus.vec_chain]);
      end

      bus.res_valid <= next_valid;
      bus.res_data  <= next_data;

      if (s1_valid && s1_mode == MODE_ACCUM)
        acc[s1_chain] <= s1_eof ? '0 : acc_total;

      if (cfg_hit) begin
        firmware[cfg_slot] <= bus.config_data[2:0];
        acc[cfg_slot]      <= '0;
      end
    end
  end
endmodule

// File: tb/tb_vector_reduce_accum_unit.sv
// Bench for vector_reduce_accum_unit: constant vector table, hand-written accumulation
// and config sequences, and random traffic checked against a cycle-indexed reference model.
module tb_vector_reduce_accum_unit;
  localparam int N     = 8;
  localparam int M     = 4;
  localparam int DW    = 32;
  localparam int MC    = 4;
  localparam int PCID  = 0;
  localparam int CW    = 2;
  localparam int DEPTH = 4096;

  typedef logic [N-1:0][DW-1:0] vec_t;

  typedef struct {
    bit            cfg;
    logic [2:0]    mode;
    logic [CW-1:0] chain;
    bit            eof;
    vec_t          vec;
    bit            exp_valid;
    vec_t          exp_data;
  } vector_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   mon_en = 1'b0;

  bit         exp_v [DEPTH];
  vec_t       exp_d [DEPTH];
  logic [2:0]    m_fw  [MC];
  logic [DW-1:0] m_acc [MC];

  vector_rec_t tbl [14];

  vector_reduce_accum_unit_if #(.N(N), .DATA_WIDTH(DW), .CW(CW)) bus ();

  vector_reduce_accum_unit #(
    .N(N), .M(M), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .PERSONAL_CONFIG_ID(PCID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time bound exceeded, got running expected finished");
    $fatal(1);
  end

  function automatic vec_t mk8(input logic [DW-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
    vec_t v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
    return v;
  endfunction

  function automatic vec_t fill(input logic [DW-1:0] a);
    return mk8(a, a, a, a, a, a, a, a);
  endfunction

  function automatic vector_rec_t rec(input bit cfg, input logic [2:0] mode, input int ch,
                                      input bit eof, input vec_t v, input bit ev, input vec_t ed);
    vector_rec_t r;
    r.cfg = cfg; r.mode = mode; r.chain = CW'(ch); r.eof = eof;
    r.vec = v; r.exp_valid = ev; r.exp_data = ed;
    return r;
  endfunction

  task automatic check_output(input string name, input vec_t act, input vec_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference behaviour: whole-vector arithmetic on the mode rules, one call per accepted vector.
  function automatic void model_vector(input logic [2:0] mode, input logic [CW-1:0] ch,
                                       input bit eof, input vec_t v,
                                       output bit ov, output vec_t od);
    logic [DW-1:0] total;
    int best;
    total = '0;
    for (int i = 0; i < N; i++) total += v[i];
    od = '0;
    ov = 1'b1;
    case (mode)
      3'd1: od[0] = total;
      3'd2: for (int g = 0; g < N/M; g++) for (int k = 0; k < M; k++) od[g] += v[g*M+k];
      3'd3: begin
        best = 0;
        for (int i = 0; i < N; i++) if ($signed(v[i]) > $signed(v[best])) best = i;
        od[0] = v[best];
        od[1] = DW'(best);
      end
      3'd4: begin
        m_acc[ch] += total;
        if (eof) begin
          od[0] = m_acc[ch];
          m_acc[ch] = '0;
        end else begin
          ov = 1'b0;
        end
      end
      default: od = v;
    endcase
  endfunction

  task automatic apply_stimulus(input bit tr, input bit vv, input bit eof, input logic [CW-1:0] ch,
                                input vec_t v, input logic [7:0] cid, input logic [7:0] cdata);
    bit   ov;
    vec_t od;
    int   slot;
    bus.tracing     = tr;
    bus.vec_valid   = vv;
    bus.vec_eof     = eof;
    bus.vec_chain   = ch;
    bus.vec_data    = v;
    bus.config_id   = cid;
    bus.config_data = cdata;
    if (tr && vv) begin
      model_vector(m_fw[ch], ch, eof, v, ov, od);
      if (cyc + 2 < DEPTH) begin
        exp_v[cyc+2] = ov;
        exp_d[cyc+2] = od;
      end
    end else if (!tr) begin
      slot = int'(cid) - PCID;
      if (slot >= 0 && slot < MC) begin
        m_fw[slot]  = cdata[2:0];
        m_acc[slot] = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input logic [2:0] mode);
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'(PCID + ch), {5'b0, mode});
  endtask

  task automatic send(input int ch, input bit eof, input vec_t v);
    apply_stimulus(1'b1, 1'b1, eof, CW'(ch), v, 8'd0, 8'd0);
  endtask

  task automatic idle();
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, 8'd0, 8'd0);
  endtask

  task automatic expect_now(input string name, input bit ev, input vec_t ed);
    check_output({name, "_valid"}, vec_t'(bus.res_valid), vec_t'(ev));
    if (ev) check_output({name, "_data"}, bus.res_data, ed);
  endtask

  task automatic do_reset();
    mon_en        = 1'b0;
    rst           = 1'b1;
    bus.tracing   = 1'b1;
    bus.vec_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_output("reset_valid", vec_t'(bus.res_valid), '0);
    check_output("reset_data", bus.res_data, '0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_v[i] = 1'b0;
    for (int c = 0; c < MC; c++) begin
      m_fw[c]  = 3'd0;
      m_acc[c] = '0;
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  // Every cycle the result port must match whatever the model scheduled for that cycle.
  always @(negedge clk) begin
    if (mon_en && cyc < DEPTH) begin
      check_output("pipe_valid", vec_t'(bus.res_valid), vec_t'(exp_v[cyc]));
      if (exp_v[cyc]) check_output("pipe_data", bus.res_data, exp_d[cyc]);
    end
  end

  initial begin
    vec_t seq;
    vec_t rv;
    bit   tr;
    seq = mk8(1, 2, 3, 4, 5, 6, 7, 8);

    tbl[0]  = rec(1, 0, 0, 0, seq, 1, seq);
    tbl[1]  = rec(1, 1, 0, 0, seq, 1, mk8(36, 0, 0, 0, 0, 0, 0, 0));
    tbl[2]  = rec(1, 2, 0, 0, seq, 1, mk8(10, 26, 0, 0, 0, 0, 0, 0));
    tbl[3]  = rec(1, 3, 0, 0, mk8(-5, 7, 3, 7, 0, -1, 2, 1), 1, mk8(7, 1, 0, 0, 0, 0, 0, 0));
    tbl[4]  = rec(0, 3, 0, 0, fill(-1), 1, mk8(-1, 0, 0, 0, 0, 0, 0, 0));
    tbl[5]  = rec(1, 5, 3, 0, seq, 1, seq);
    tbl[6]  = rec(1, 2, 1, 0, mk8(32'h7FFFFFFF, 1, 0, 0, 5, 5, 5, 5), 1,
                  mk8(32'h80000000, 20, 0, 0, 0, 0, 0, 0));
    tbl[7]  = rec(1, 4, 1, 0, fill(1), 0, '0);
    tbl[8]  = rec(0, 4, 1, 0, fill(1), 0, '0);
    tbl[9]  = rec(0, 4, 1, 1, fill(1), 1, mk8(24, 0, 0, 0, 0, 0, 0, 0));
    tbl[10] = rec(0, 4, 1, 1, fill(1), 1, mk8(8, 0, 0, 0, 0, 0, 0, 0));
    tbl[11] = rec(1, 1, 0, 1, seq, 1, mk8(36, 0, 0, 0, 0, 0, 0, 0));
    tbl[12] = rec(1, 3, 2, 0, mk8(3, -2, 9, 9, -7, 0, 9, 1), 1, mk8(9, 2, 0, 0, 0, 0, 0, 0));
    tbl[13] = rec(1, 2, 2, 0, mk8(-1, -1, -1, -1, 2, 2, 2, 2), 1, mk8(-4, 8, 0, 0, 0, 0, 0, 0));

    bus.tracing     = 1'b1;
    bus.vec_valid   = 1'b0;
    bus.vec_eof     = 1'b0;
    bus.vec_chain   = '0;
    bus.vec_data    = '0;
    bus.config_id   = 8'd0;
    bus.config_data = 8'd0;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].cfg) cfg(int'(tbl[i].chain), tbl[i].mode);
      send(int'(tbl[i].chain), tbl[i].eof, tbl[i].vec);
      idle();
      @(negedge clk);
      expect_now($sformatf("table%0d", i), tbl[i].exp_valid, tbl[i].exp_data);
    end

    // Back-to-back frame on one chain, then a second frame that must start from zero.
    cfg(1, 3'd4);
    send(1, 1'b0, fill(1));
    send(1, 1'b0, fill(1));
    send(1, 1'b1, fill(1));
    idle();
    @(negedge clk);
    expect_now("b2b_frame1", 1'b1, mk8(24, 0, 0, 0, 0, 0, 0, 0));
    send(1, 1'b0, fill(1));
    send(1, 1'b1, fill(1));
    idle();
    @(negedge clk);
    expect_now("b2b_frame2", 1'b1, mk8(16, 0, 0, 0, 0, 0, 0, 0));

    // Interleaved chains with independent totals, one of them wrapping.
    cfg(0, 3'd4);
    cfg(1, 3'd4);
    send(0, 1'b0, mk8(32'h7FFFFFFF, 0, 0, 0, 0, 0, 0, 0));
    send(1, 1'b0, fill(2));
    send(0, 1'b1, mk8(1, 0, 0, 0, 0, 0, 0, 0));
    send(1, 1'b1, fill(2));
    @(negedge clk);
    expect_now("interleave_ch0", 1'b1, mk8(32'h80000000, 0, 0, 0, 0, 0, 0, 0));
    idle();
    @(negedge clk);
    expect_now("interleave_ch1", 1'b1, mk8(32, 0, 0, 0, 0, 0, 0, 0));

    // Config window: in-range write, out-of-range writes, and vectors offered while not tracing.
    cfg(2, 3'd1);
    send(2, 1'b0, seq);
    idle();
    @(negedge clk);
    expect_now("cfg_sets_sum", 1'b1, mk8(36, 0, 0, 0, 0, 0, 0, 0));
    cfg(0, 3'd3);
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'(PCID + MC), 8'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'd200, 8'd0);
    send(0, 1'b0, mk8(-5, 7, 3, 7, 0, -1, 2, 1));
    idle();
    @(negedge clk);
    expect_now("cfg_out_of_range", 1'b1, mk8(7, 1, 0, 0, 0, 0, 0, 0));
    apply_stimulus(1'b0, 1'b1, 1'b1, '0, seq, 8'd100, 8'd0);
    idle();
    idle();
    @(negedge clk);
    expect_now("no_accept_untraced", 1'b0, '0);

    // Reset in the middle of a frame drops both the partial sum and in-flight vectors.
    cfg(0, 3'd4);
    send(0, 1'b0, fill(5));
    send(0, 1'b0, fill(5));
    do_reset();
    cfg(0, 3'd4);
    send(0, 1'b1, fill(1));
    idle();
    @(negedge clk);
    expect_now("rst_clears_acc", 1'b1, mk8(8, 0, 0, 0, 0, 0, 0, 0));

    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      tr = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++)
        rv[i] = $urandom_range(0, 1) ? DW'($urandom()) : DW'($urandom_range(0, 6)) - DW'(3);
      apply_stimulus(tr, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                     CW'($urandom_range(0, MC - 1)), rv, 8'($urandom_range(0, 7)),
                     $urandom_range(0, 1) ? 8'd4 : 8'($urandom_range(0, 255)));
    end
    repeat (3) idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
